// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding,
// default operand width and the iteration-counter width helper.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bits needed to count 0..w-1; never less than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor_cell.sv
// One-bit full subtractor: d = x - y - bin, bout set when the bit borrows.
module serial_subtractor_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow out of a single bit position.
  always_comb begin
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one difference bit per clock.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. in_ready is high only in IDLE and out_valid only in DONE; both
// come straight from the state register, so neither depends combinationally on
// any input. The producer holds a/b until in_ready; the result fields stay
// stable in DONE until out_ready is seen, and keep their values afterwards.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t state, state_next;

  logic [WIDTH-1:0] sa, sb, res;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             a_msb, b_msb;
  logic             borrow_q, overflow_q;
  logic             cell_d, cell_bout;
  logic             last_bit;

  assign last_bit = (state == ST_RUN) && (cnt == CNT_LAST);

  serial_subtractor_cell u_cell (
    .x    (sa[0]),
    .y    (sb[0]),
    .bin  (borrow),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state decode: accept in IDLE, step WIDTH bits in RUN, hold in DONE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (in_valid) state_next = ST_RUN;
      ST_RUN:  if (last_bit) state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand shifters, borrow, counter and the result/flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa         <= '0;
      sb         <= '0;
      res        <= '0;
      diff_q     <= '0;
      cnt        <= '0;
      borrow     <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            sa     <= a;
            sb     <= b;
            borrow <= 1'b0;
            cnt    <= '0;
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
          end
        end
        ST_RUN: begin
          sa     <= {1'b0, sa[WIDTH-1:1]};
          sb     <= {1'b0, sb[WIDTH-1:1]};
          res    <= {cell_d, res[WIDTH-1:1]};
          borrow <= cell_bout;
          cnt    <= cnt + 1'b1;
          // The final bit completes the result; publish it together with the
          // flags so the outputs only ever change on entry to DONE.
          if (last_bit) begin
            diff_q     <= {cell_d, res[WIDTH-1:1]};
            borrow_q   <= cell_bout;
            overflow_q <= (a_msb != b_msb) && (cell_d != a_msb);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (state == ST_IDLE);
  assign out_valid  = (state == ST_DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed cases, backpressure, reset mid-run
// and randomised operations against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;
  localparam int TIMEOUT = 50;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         overflow;

  int checks   = 0;
  int failures = 0;

  // Scoreboard entries packed as {overflow, borrow, diff}.
  logic [W+1:0] exp_q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] av, input logic [W-1:0] bv);
    int ua, ub, sa, sb, sd, ud;
    logic ov, br;
    logic [W-1:0] d;
    ua = int'(av);
    ub = int'(bv);
    sa = (ua >= 2**(W-1)) ? ua - 2**W : ua;
    sb = (ub >= 2**(W-1)) ? ub - 2**W : ub;
    sd = sa - sb;
    ov = (sd > 2**(W-1) - 1) || (sd < -(2**(W-1)));
    br = (ua < ub);
    ud = (ua - ub + 2**W) % (2**W);
    d  = ud[W-1:0];
    return {ov, br, d};
  endfunction

  // ---------------- driver tasks ----------------
  // Present operands until accepted; returns at the negedge after acceptance.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, output bit ok);
    int n;
    n = 0;
    in_valid = 1'b1;
    a = av;
    b = bv;
    while (!in_ready && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count negedges until out_valid, bounded.
  task automatic wait_out(output int cycles, output bit timed_out);
    cycles = 0;
    while (!out_valid && cycles < TIMEOUT) begin
      @(negedge clk);
      cycles++;
    end
    timed_out = !out_valid;
  endtask

  // Complete the result handshake; returns at the negedge after it.
  task automatic take_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (diff !== '0)        begin failures++; $display("FAIL reset_diff got=%h exp=00", diff); end
    checks++; if (borrow_out !== 1'b0) begin failures++; $display("FAIL reset_borrow got=%b exp=0", borrow_out); end
    checks++; if (overflow !== 1'b0)  begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[4] = '{8'h05, 8'h03, 8'h80, 8'h7F};
    logic [W-1:0] tb[4] = '{8'h03, 8'h05, 8'h01, 8'hFF};
    logic [W-1:0] td[4] = '{8'h02, 8'hFE, 8'h7F, 8'h80};
    logic         tr[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic         to[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    bit ok, tmo;
    int cyc;
    for (int i = 0; i < 4; i++) begin
      send(ta[i], tb[i], ok);
      checks++; if (!ok) begin failures++; $display("FAIL dir%0d_accept got=0 exp=1", i); end
      wait_out(cyc, tmo);
      checks++; if (tmo || cyc != W) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, cyc, W); end
      checks++; if (diff !== td[i]) begin failures++; $display("FAIL dir%0d_diff got=%h exp=%h", i, diff, td[i]); end
      checks++; if (borrow_out !== tr[i]) begin failures++; $display("FAIL dir%0d_borrow got=%b exp=%b", i, borrow_out, tr[i]); end
      checks++; if (overflow !== to[i]) begin failures++; $display("FAIL dir%0d_overflow got=%b exp=%b", i, overflow, to[i]); end
      take_result();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++; $display("FAIL dir%0d_release got=v%b r%b exp=v0 r1", i, out_valid, in_ready);
      end
      checks++; if (diff !== td[i]) begin failures++; $display("FAIL dir%0d_diff_held got=%h exp=%h", i, diff, td[i]); end
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok, tmo;
    int cyc;
    send(8'hFF, 8'h01, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rmid_accept got=0 exp=1"); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL rmid_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_out_valid got=%b exp=0", out_valid); end
    checks++; if (diff !== '0)        begin failures++; $display("FAIL rmid_diff got=%h exp=00", diff); end
    checks++; if (borrow_out !== 1'b0 || overflow !== 1'b0) begin
      failures++; $display("FAIL rmid_flags got=b%b o%b exp=b0 o0", borrow_out, overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    // No result from the aborted run may appear.
    repeat (W + 2) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_no_result got=%b exp=0", out_valid); end
    end
    send(8'h09, 8'h04, ok);
    wait_out(cyc, tmo);
    checks++; if (tmo) begin failures++; $display("FAIL rmid_next_timeout got=timeout exp=out_valid"); end
    checks++; if (diff !== 8'h05) begin failures++; $display("FAIL rmid_next_diff got=%h exp=05", diff); end
    take_result();
  endtask

  task automatic test_back_to_back();
    bit ok, tmo;
    int cyc;
    send(8'h92, 8'hAB, ok);
    wait_out(cyc, tmo);
    checks++; if (tmo) begin failures++; $display("FAIL bp_timeout got=timeout exp=out_valid"); end
    // Stall the consumer while a producer pushes operands that must be ignored.
    in_valid = 1'b1;
    a = 8'h11;
    b = 8'h22;
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++; $display("FAIL bp_hold%0d got=v%b r%b exp=v1 r0", i, out_valid, in_ready);
      end
      checks++; if (diff !== 8'hE7 || borrow_out !== 1'b1) begin
        failures++; $display("FAIL bp_stable%0d got=%h/%b exp=e7/1", i, diff, borrow_out);
      end
      @(negedge clk);
    end
    // Release the result and offer new operands on the same edge.
    out_ready = 1'b1;
    a = 8'h10;
    b = 8'h10;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL b2b_idle got=v%b r%b exp=v0 r1", out_valid, in_ready);
    end
    checks++; if (diff !== 8'hE7) begin failures++; $display("FAIL b2b_diff_held got=%h exp=e7", diff); end
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(cyc, tmo);
    checks++; if (tmo || cyc != W) begin failures++; $display("FAIL b2b_latency got=%0d exp=%0d", cyc, W); end
    checks++; if (diff !== 8'h00 || borrow_out !== 1'b0) begin
      failures++; $display("FAIL b2b_result got=%h/%b exp=00/0", diff, borrow_out);
    end
    take_result();
  endtask

  task automatic test_random();
    bit ok, tmo;
    int cyc, stall, sent, got;
    logic [W-1:0] av, bv;
    logic [W+1:0] exp, held;
    sent = 0;
    got  = 0;
    for (int i = 0; i < 1000; i++) begin
      av = W'($urandom_range(0, 2**W - 1));
      bv = W'($urandom_range(0, 2**W - 1));
      send(av, bv, ok);
      if (ok) begin
        exp_q.push_back(ref_model(av, bv));
        sent++;
      end
      // Occasionally wiggle in_valid with junk while busy.
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b1;
        a = W'($urandom);
        b = W'($urandom);
      end
      wait_out(cyc, tmo);
      in_valid = 1'b0;
      if (tmo) begin
        checks++; failures++;
        $display("FAIL rnd%0d_timeout got=timeout exp=out_valid", i);
      end else begin
        held = {overflow, borrow_out, diff};
        stall = $urandom_range(0, 3);
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          checks++; if (out_valid !== 1'b1 || {overflow, borrow_out, diff} !== held) begin
            failures++; $display("FAIL rnd%0d_stall got=v%b %h exp=v1 %h", i, out_valid, {overflow, borrow_out, diff}, held);
          end
        end
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        got++;
        checks++; if ({overflow, borrow_out, diff} !== exp) begin
          failures++; $display("FAIL rnd%0d a=%h b=%h got=%h exp=%h", i, av, bv, {overflow, borrow_out, diff}, exp);
        end
        take_result();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rnd%0d_dup got=%b exp=0", i, out_valid); end
      end
    end
    checks++; if (got != sent || exp_q.size() != 0) begin
      failures++; $display("FAIL rnd_count got=%0d exp=%0d left=%0d", got, sent, exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
